// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               between the datapath load/store port and a word-wide memory.
//               Define DCACHE_STATS_EN to build the hit/miss statistic counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache #(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int C_OFF_W = $clog2(WORDS_PER_LINE);
    localparam int C_IDX_W = $clog2(NUM_LINES);
    localparam int C_TAG_W = 30 - C_OFF_W - C_IDX_W;
    localparam logic [C_OFF_W-1:0] C_LAST_BEAT = C_OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [C_OFF_W-1:0]     beat_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [C_TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]            data_q [NUM_LINES*WORDS_PER_LINE];

    logic [C_OFF_W-1:0]     w_off;
    logic [C_IDX_W-1:0]     w_idx;
    logic [C_TAG_W-1:0]     w_tag;
    logic                   w_hit;
    logic                   w_rd_hit;
    logic                   w_refill_start;
    logic                   w_unused;

    assign w_off          = cpu_addr[2 +: C_OFF_W];
    assign w_idx          = cpu_addr[2+C_OFF_W +: C_IDX_W];
    assign w_tag          = cpu_addr[31 -: C_TAG_W];
    assign w_hit          = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_rd_hit       = (state_q == S_IDLE) && cpu_read && !cpu_write && w_hit;
    assign w_refill_start = (state_q == S_IDLE) && cpu_read && !cpu_write && !w_hit;
    assign w_unused       = ^cpu_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_write) begin
                        state_q <= S_WRITE;
                    end else if (w_refill_start) begin
                        state_q        <= S_REFILL;
                        beat_q         <= '0;
                        valid_q[w_idx] <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == C_LAST_BEAT) begin
                            valid_q[w_idx] <= 1'b1;
                            state_q        <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        state_q <= S_WRITE == S_WRITE ? S_DONE : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && mem_ready) begin
            data_q[{w_idx, beat_q}] <= mem_rdata;
            if (beat_q == C_LAST_BEAT) begin
                tag_q[w_idx] <= w_tag;
            end
        end
        if (state_q == S_WRITE && mem_ready && w_hit) begin
            data_q[{w_idx, w_off}] <= cpu_wdata;
        end
    end

    always_comb begin
        cpu_rdata = '0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_write) begin
                        stall = 1'b1;
                    end else if (cpu_read) begin
                        if (w_hit) cpu_rdata = data_q[{w_idx, w_off}];
                        else       stall     = 1'b1;
                    end
                end
                S_REFILL: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {w_tag, w_idx, beat_q, 2'b00};
                end
                S_WRITE: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {cpu_addr[31:2], 2'b00};
                    mem_wdata = cpu_wdata;
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (w_rd_hit && hit_q != 16'hFFFF)        hit_q  <= hit_q + 16'd1;
            if (w_refill_start && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_rd_hit;
    assign hit_count      = 16'd0;
    assign miss_count     = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Directed self-checking bench for data_cache with a 2-cycle
//               memory responder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] rd_addr_q [$];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wait_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        last_req;

    data_cache dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Memory answers each request one cycle after it has been waiting one cycle.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_req) begin
            if (wait_cnt >= 1) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem_m[mem_addr] = mem_wdata;
                    wr_cnt++;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                end else begin
                    mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'd0;
                    rd_cnt++;
                    rd_addr_q.push_back(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int n);
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (stall) check("read_timeout", 32'd1, 32'd0);
        d        = cpu_rdata;
        last_req = mem_req;
        @(posedge clk); #1;
        cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] w, input logic rd_too,
                            output int n);
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_wdata = w;
        cpu_write = 1'b1;
        cpu_read  = rd_too;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (stall) check("write_timeout", 32'd1, 32'd0);
        last_req = mem_req;
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          n;
        int          rd0;
        int          wr0;
        int          k;

        for (int i = 0; i < 4; i++) begin
            mem_m[32'h100 + 4*i] = 32'hA0 + i;
            mem_m[32'h300 + 4*i] = 32'hB0 + i;
            mem_m[32'h400 + 4*i] = 32'hD0 + i;
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        reset     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall",   {31'd0, stall},   32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we",  {31'd0, mem_we},  32'd0);
        check("rst_mem_addr", mem_addr,        32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_hits",  {16'd0, hit_count},  32'd0);
        check("rst_misses", {16'd0, miss_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_stall",  {31'd0, stall},   32'd0);
        check("idle_rdata",  cpu_rdata,        32'd0);

        // Cold read of 0x100: four beats then the held load hits.
        rd0 = rd_cnt;
        rd_addr_q.delete();
        do_read(32'h100, d, n);
        check("cold_beats", rd_cnt - rd0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (rd_addr_q.size() > i) check("cold_beat_addr", rd_addr_q[i], 32'h100 + 4*i);
            else check("cold_beat_addr_missing", 32'd0, 32'h100 + 4*i);
        end
        check("cold_rdata", d, 32'hA0);
        check("cold_stalled", {31'd0, n > 0}, 32'd1);

        rd0 = rd_cnt;
        do_read(32'h108, d, n);
        check("hit_rdata", d, 32'hA2);
        check("hit_nostall", n, 32'd0);
        check("hit_noreq", {31'd0, last_req}, 32'd0);
        check("hit_nobeats", rd_cnt - rd0, 32'd0);

        // Store hit then readback.
        wr0 = wr_cnt;
        do_write(32'h104, 32'hDEADBEEF, 1'b0, n);
        check("wr_count", wr_cnt - wr0, 32'd1);
        check("wr_addr", last_wr_addr, 32'h104);
        check("wr_data", last_wr_data, 32'hDEADBEEF);
        check("wr_done_noreq", {31'd0, last_req}, 32'd0);
        rd0 = rd_cnt;
        do_read(32'h104, d, n);
        check("wr_hit_rdata", d, 32'hDEADBEEF);
        check("wr_hit_nostall", n, 32'd0);
        check("wr_hit_nobeats", rd_cnt - rd0, 32'd0);

        // Store miss must not allocate.
        wr0 = wr_cnt;
        do_write(32'h2000, 32'h5, 1'b0, n);
        check("wmiss_count", wr_cnt - wr0, 32'd1);
        rd0 = rd_cnt;
        do_read(32'h2000, d, n);
        check("wmiss_refill", rd_cnt - rd0, 32'd4);
        check("wmiss_rdata", d, 32'h5);

        // Conflict on the same index evicts 0x100.
        rd0 = rd_cnt;
        do_read(32'h300, d, n);
        check("conf_beats", rd_cnt - rd0, 32'd4);
        check("conf_rdata", d, 32'hB0);
        rd0 = rd_cnt;
        do_read(32'h100, d, n);
        check("evict_beats", rd_cnt - rd0, 32'd4);
        check("evict_rdata", d, 32'hA0);

        // Read and write together behave as a store.
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_write(32'h108, 32'h77, 1'b1, n);
        check("both_wr", wr_cnt - wr0, 32'd1);
        check("both_nord", rd_cnt - rd0, 32'd0);
        do_read(32'h108, d, n);
        check("both_rdata", d, 32'h77);
        check("both_hit", n, 32'd0);

`ifdef DCACHE_STATS_EN
        check("stat_hits", {16'd0, hit_count}, 32'd7);
        check("stat_misses", {16'd0, miss_count}, 32'd4);
`else
        check("stat_hits_off", {16'd0, hit_count}, 32'd0);
        check("stat_misses_off", {16'd0, miss_count}, 32'd0);
`endif

        // Reset in the middle of a refill of 0x400.
        @(posedge clk); #1;
        cpu_addr = 32'h400;
        cpu_read = 1'b1;
        rd0 = rd_cnt;
        k = 0;
        @(negedge clk);
        while (rd_cnt - rd0 < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (rd_cnt - rd0 < 2) check("mid_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_hits", {16'd0, hit_count}, 32'd0);
        check("mid_rst_misses", {16'd0, miss_count}, 32'd0);
        cpu_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rd0 = rd_cnt;
        rd_addr_q.delete();
        do_read(32'h400, d, n);
        check("rerefill_beats", rd_cnt - rd0, 32'd4);
        if (rd_addr_q.size() > 0) check("rerefill_addr0", rd_addr_q[0], 32'h400);
        else check("rerefill_addr0_missing", 32'd0, 32'h400);
        check("rerefill_rdata", d, 32'hD0);
`ifdef DCACHE_STATS_EN
        check("post_hits", {16'd0, hit_count}, 32'd1);
        check("post_misses", {16'd0, miss_count}, 32'd1);
`else
        check("post_hits_off", {16'd0, hit_count}, 32'd0);
        check("post_misses_off", {16'd0, miss_count}, 32'd0);
`endif
        @(negedge clk);
        check("end_idle_stall", {31'd0, stall}, 32'd0);
        check("end_idle_req", {31'd0, mem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
- REQ-001: NUM_LINES, default 32, number of direct-mapped lines, a power of two.
- REQ-002: WORDS_PER_LINE, default 4, 32-bit words per line, a power of two.
- REQ-003: clk  input  1  sole clock, rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: cpu_addr  input  32  byte address from datapath ALUResult; bits [1:0] ignored.
- REQ-006: cpu_wdata  input  32  store data from datapath WriteData.
- REQ-007: cpu_read  input  1  load request, level, held while stall=1.
- REQ-008: cpu_write  input  1  store request, level, held while stall=1.
- REQ-009: cpu_rdata  output  32  load data to datapath Read_Data.
- REQ-010: stall  output  1  freezes datapath PC while high.
- REQ-011: mem_req, mem_we  output  1 each  memory request, write qualifier.
- REQ-012: mem_addr, mem_wdata  output  32 each  word-aligned memory address, write data.
- REQ-013: mem_ready  input  1  memory accepts write or returns read beat this cycle.
- REQ-014: mem_rdata  input  32  read beat data, valid when mem_ready=1 and mem_we=0.
- REQ-015: hit_count, miss_count  output  16 each  access statistics (see Configuration).

Function
- REQ-016: Address split at defaults: offset [3:2], index [8:4], tag [31:9]; widths derive from parameters.
- REQ-017: The cache is write-through, no-write-allocate, holding per line: a valid bit, tag and WORDS_PER_LINE data words.
- REQ-018: FSM states are IDLE, REFILL, WRITE and DONE.
- REQ-019: In IDLE with cpu_read on a hit, cpu_rdata = addressed word combinationally, stall=0 and the state stays IDLE.
- REQ-020: In IDLE with cpu_read on a miss, stall=1 in the same cycle and the next state is REFILL with beat counter=0.
- REQ-021: In REFILL, mem_req=1, mem_we=0 and mem_addr = {tag,index,beat,2'b00}; each mem_ready writes mem_rdata into word[beat] and increments beat; stall=1 throughout.
- REQ-022: On the last beat's mem_ready, the line's tag and valid bit are written and the next state is IDLE; the held load then hits with zero extra cycles.
- REQ-023: In IDLE with cpu_write, stall=1 in the same cycle and the next state is WRITE.
- REQ-024: In WRITE, mem_req=1, mem_we=1, mem_addr = {cpu_addr[31:2],2'b00}, mem_wdata=cpu_wdata and stall=1; on mem_ready, the word is updated on a tag hit, the line is unchanged on a miss, and the next state is DONE.
- REQ-025: In DONE, stall=0 and mem_req=0, no request is evaluated, and the next state is IDLE, so the store retires exactly once.
- REQ-026: cpu_read and cpu_write both high is treated as a write.
- REQ-027: Neither request in IDLE gives stall=0 and mem_req=0.
- REQ-028: mem_req stays high until mem_ready; memory latency is unbounded.
- REQ-029: cpu_rdata is 0 when there is no read hit in IDLE.

Reset
- REQ-030: reset=0 asynchronously forces IDLE, beat=0, all valid bits=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 and both counters=0.
- REQ-031: Reset during REFILL or WRITE abandons the transaction immediately; the partially refilled line stays invalid.
- REQ-032: Data array contents are not reset.

Configuration
- REQ-033: With DCACHE_STATS_EN defined, hit_count increments on each IDLE read hit cycle that retires a load, miss_count increments on each REFILL entry, and both saturate at 16'hFFFF.
- REQ-034: Without DCACHE_STATS_EN, hit_count and miss_count are constant 0 and no counter registers exist.

Verification
- REQ-035: Cold read of 0x100 with mem_ready returning 0xA0..0xA3 at 2-cycle latency: 4 beats at 0x100/104/108/10C, stall high for the refill, then cpu_rdata=0xA0 with stall=0.
- REQ-036: Read 0x108 after REQ-035 gives cpu_rdata=0xA2 with stall=0 in the same cycle and no mem_req.
- REQ-037: Write 0x104 with data 0xDEADBEEF (hit): one mem write at 0x104, one DONE cycle with stall=0, then read 0x104 returns 0xDEADBEEF without mem_req.
- REQ-038: Write miss to 0x2000 with data 0x5: one mem write, then a read of 0x2000 triggers a refill, proving no allocate.
- REQ-039: Conflict read of 0x300 (same index as 0x100, different tag): a refill replaces the line, then read 0x100 misses again.
- REQ-040: Reset asserted after beat 2 of a refill: stall=0 and mem_req=0 immediately; re-read of the same address performs a full 4-beat refill; with DCACHE_STATS_EN, counters read 0 after reset.
